// File: rtl/axi_stream_rr_arbiter_if.sv
// Stream bundle seen by the round-robin arbiter: NUM_SRC upstream channels and one downstream.
// The master modport is the environment side and the slave modport is the arbiter side.
interface axi_stream_rr_arbiter_if #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_SRC-1:0]            s_tvalid;
    logic [NUM_SRC-1:0]            s_tready;
    logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_SRC-1:0]            s_tlast;
    logic                          m_tvalid;
    logic                          m_tready;
    logic [DATA_WIDTH-1:0]         m_tdata;
    logic                          m_tlast;

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream consumer among NUM_SRC sources.
// Only grant/state is registered; the data path is a pure combinational mux.
module axi_stream_rr_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned ID_WIDTH  = $clog2(NUM_SRC)
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    axi_stream_rr_arbiter_if.slave  bus,
    output logic [ID_WIDTH-1:0]     grant_id,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    pkt_count
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                r_state;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic                  w_any;
    logic [ID_WIDTH-1:0]   w_pick;
    logic [ID_WIDTH-1:0]   w_idx;
    logic                  w_xfer;
    logic                  w_last;

    // Scan last_grant+1 .. last_grant+NUM_SRC so the previous winner is considered last.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last_grant;
        w_idx  = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_idx = ID_WIDTH'((32'(r_last_grant) + k) % NUM_SRC);
            if (!w_any && bus.s_tvalid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = '0;
        bus.m_tlast  = 1'b0;
        bus.s_tready = '0;
        if (r_state == StLocked) begin
            bus.m_tvalid          = bus.s_tvalid[r_grant];
            bus.m_tdata           = bus.s_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
            bus.m_tlast           = bus.s_tlast[r_grant];
            bus.s_tready[r_grant] = bus.m_tready;
        end
    end

    assign w_xfer = (r_state == StLocked) && bus.s_tvalid[r_grant] && bus.m_tready;
    assign w_last = bus.s_tlast[r_grant];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state      <= StIdle;
            r_last_grant <= ID_WIDTH'(NUM_SRC - 1);
            r_grant      <= '0;
            r_pkt_count  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= StLocked;
                    end
                end
                StLocked: begin
                    // Lock is released only by the TLAST beat; a valid gap keeps the grant.
                    if (w_xfer && w_last) begin
                        r_last_grant <= r_grant;
                        r_pkt_count  <= r_pkt_count + 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign grant_id  = r_grant;
    assign busy      = (r_state == StLocked);
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed bench for axi_stream_rr_arbiter: per-source beat queues drive the inputs and a
// scoreboard of expected output beats (source, data, last) is checked as beats leave the DUT.
module tb_axi_stream_rr_arbiter;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          aclk = 1'b0;
    logic          areset_n = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic [CW-1:0] pkt_count;

    axi_stream_rr_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

    axi_stream_rr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 aclk = ~aclk;

    beat_t        src_q[NS][$];
    exp_t         exp_q[$];
    logic [NS-1:0] en;
    logic          tready;
    int            checks = 0;
    int            errors = 0;

    logic [NS-1:0] smp_tready;
    logic [1:0]    smp_grant;
    logic          smp_busy;
    logic          smp_mfire;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                bus.s_tvalid[i]          = 1'b1;
                bus.s_tdata[i*DW +: DW]  = src_q[i][0].data;
                bus.s_tlast[i]           = src_q[i][0].last;
            end else begin
                bus.s_tvalid[i]          = 1'b0;
                bus.s_tdata[i*DW +: DW]  = '0;
                bus.s_tlast[i]           = 1'b0;
            end
        end
        bus.m_tready = tready;
    endtask

    // One clock: drive just after an edge, sample at the falling edge, retire accepted beats.
    task automatic step();
        logic [NS-1:0] fired;
        exp_t          e;
        drive();
        @(negedge aclk);
        smp_tready = bus.s_tready;
        smp_grant  = grant_id;
        smp_busy   = busy;
        smp_mfire  = bus.m_tvalid && bus.m_tready;
        fired      = bus.s_tvalid & bus.s_tready;
        if (smp_mfire) begin
            chk("beat expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("m_tdata", 64'(bus.m_tdata), 64'(e.data));
                chk("m_tlast", 64'(bus.m_tlast), 64'(e.last));
                chk("grant_id on beat", 64'(grant_id), 64'(e.src));
            end
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (fired[i]) void'(src_q[i].pop_front());
        end
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int c = 0;
        while (exp_q.size() > 0 && c < max_cycles) begin
            step();
            c++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push(input int src, input logic [DW-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[src].push_back(b);
    endtask

    task automatic expect_beat(input int src, input logic [DW-1:0] data, input logic last);
        exp_t e;
        e.src  = 2'(src);
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        en = '0;
    endtask

    task automatic apply_reset();
        areset_n = 1'b0;
        clear_all();
        drive();
        @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int gap;
        tready       = 1'b1;
        en           = '0;
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        apply_reset();

        // Reset state
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset grant_id", 64'(grant_id), 64'd0);
        chk("reset pkt_count", 64'(pkt_count), 64'd0);
        chk("reset m_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("reset s_tready", 64'(bus.s_tready), 64'd0);

        // Single source, 8 beats: one IDLE cycle, then 8 back-to-back transfers
        for (int b = 0; b < 8; b++) begin
            push(0, 32'hdeadbeef + 32'(b), b == 7);
            expect_beat(0, 32'hdeadbeef + 32'(b), b == 7);
        end
        en = 4'b0001;
        step();
        chk("t1 idle no transfer", 64'(smp_mfire), 64'd0);
        chk("t1 idle busy", 64'(smp_busy), 64'd0);
        for (int b = 0; b < 8; b++) begin
            step();
            chk("t1 consecutive beat", 64'(smp_mfire), 64'd1);
        end
        chk("t1 busy after", 64'(busy), 64'd0);
        chk("t1 pkt_count", 64'(pkt_count), 64'd1);
        chk("t1 grant_id held", 64'(grant_id), 64'd0);

        // Round-robin: all four sources offer two 2-beat packets each
        apply_reset();
        for (int s = 0; s < NS; s++) begin
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 2; b++) begin
                    push(s, (32'(s) << 28) | 32'(p*2 + b), b == 1);
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < NS; s++) begin
                for (int b = 0; b < 2; b++) begin
                    expect_beat(s, (32'(s) << 28) | 32'(p*2 + b), b == 1);
                end
            end
        end
        en = 4'b1111;
        drain("t2 drain", 100);
        chk("t2 pkt_count", 64'(pkt_count), 64'd8);

        // Backpressure and valid gap on source 2 while source 1 waits
        apply_reset();
        for (int b = 0; b < 6; b++) begin
            push(2, 32'h2000_0000 + 32'(b), b == 5);
            expect_beat(2, 32'h2000_0000 + 32'(b), b == 5);
        end
        push(1, 32'h1111_0000, 1'b1);
        expect_beat(1, 32'h1111_0000, 1'b1);
        en     = 4'b0100;
        tready = 1'b1;
        step();
        chk("t3 grant", 64'(grant_id), 64'd2);
        en[1] = 1'b1;
        gap   = 0;
        for (int c = 0; c < 60 && src_q[2].size() > 0; c++) begin
            tready = c[0];
            if (src_q[2].size() == 3 && gap < 2) begin
                en[2] = 1'b0;
                gap++;
            end else begin
                en[2] = 1'b1;
            end
            step();
            chk("t3 s_tready1 held low", 64'(smp_tready[1]), 64'd0);
            chk("t3 grant held", 64'(smp_grant), 64'd2);
        end
        chk("t3 src2 all sent", 64'(src_q[2].size()), 64'd0);
        tready = 1'b1;
        drain("t3 drain", 20);
        chk("t3 pkt_count", 64'(pkt_count), 64'd2);

        // Source 1 back-to-back with source 3 pending: 3 goes before 1's second packet
        apply_reset();
        push(1, 32'h0000_00a0, 1'b0);
        push(1, 32'h0000_00a1, 1'b1);
        push(1, 32'h0000_00b0, 1'b1);
        push(3, 32'h0000_0030, 1'b1);
        expect_beat(1, 32'h0000_00a0, 1'b0);
        expect_beat(1, 32'h0000_00a1, 1'b1);
        expect_beat(3, 32'h0000_0030, 1'b1);
        expect_beat(1, 32'h0000_00b0, 1'b1);
        en = 4'b0010;
        step();
        en = 4'b1010;
        drain("t4 drain", 40);
        chk("t4 pkt_count", 64'(pkt_count), 64'd3);

        // Reset after beat 3 of 8
        for (int b = 0; b < 8; b++) begin
            push(0, 32'hdeadbeef + 32'(b), b == 7);
            expect_beat(0, 32'hdeadbeef + 32'(b), b == 7);
        end
        en = 4'b0001;
        step();
        for (int b = 0; b < 3; b++) step();
        chk("t5 busy before reset", 64'(busy), 64'd1);
        areset_n = 1'b0;
        #1;
        chk("t5 m_tvalid async", 64'(bus.m_tvalid), 64'd0);
        chk("t5 m_tlast async", 64'(bus.m_tlast), 64'd0);
        chk("t5 s_tready async", 64'(bus.s_tready), 64'd0);
        chk("t5 busy async", 64'(busy), 64'd0);
        chk("t5 pkt_count async", 64'(pkt_count), 64'd0);
        clear_all();
        push(0, 32'h0000_0050, 1'b1);
        push(3, 32'h0000_0053, 1'b1);
        expect_beat(0, 32'h0000_0050, 1'b1);
        expect_beat(3, 32'h0000_0053, 1'b1);
        en = 4'b1001;
        drive();
        @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
        drain("t5 drain", 20);
        chk("t5 pkt_count after", 64'(pkt_count), 64'd2);

        // Counter wrap: 17 single-beat packets on a 4-bit counter
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            push(k % NS, 32'h100 + 32'(k), 1'b1);
            expect_beat(k % NS, 32'h100 + 32'(k), 1'b1);
        end
        en = 4'b1111;
        drain("t6 drain", 200);
        chk("t6 pkt_count wrap", 64'(pkt_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_stream_rr_arbiter.md
Name: axi_stream_rr_arbiter

Overview:
- Shares one downstream AXI-Stream slave (e.g. axi_stream_slave) between NUM_SRC upstream AXI-Stream masters.
- Arbitration is round-robin and packet-granular: once a source is granted, it owns the output until its TLAST beat completes.
- The datapath is a pure combinational mux with no buffering; only the grant/state logic is registered.
- Sits between the stream masters and the single consumer in the stream subsystem.

Parameters:
- NUM_SRC, 4, number of upstream sources (2..16).
- DATA_WIDTH, 32, TDATA width; matches data_t.
- CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset_n  in  1  asynchronous active-low reset.
- s_tvalid  in  NUM_SRC  per-source TVALID.
- s_tready  out  NUM_SRC  per-source TREADY.
- s_tdata  in  NUM_SRC*DATA_WIDTH  per-source TDATA; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tlast  in  NUM_SRC  per-source TLAST.
- m_tvalid  out  1  downstream TVALID.
- m_tready  in  1  downstream TREADY.
- m_tdata  out  DATA_WIDTH  downstream TDATA.
- m_tlast  out  1  downstream TLAST.
- grant_id  out  $clog2(NUM_SRC)  index of the current/last granted source.
- busy  out  1  high while a packet is locked.
- pkt_count  out  CNT_WIDTH  number of completed packets, all sources.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last_grant=NUM_SRC-1, so source 0 has first priority.
  - grant_id=0, busy=0, pkt_count=0, m_tvalid=0, s_tready=all 0.
- States: IDLE, LOCKED.
- IDLE:
  - m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=all 0. No beat transfers in IDLE.
  - If any s_tvalid is high, pick the first requesting index scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Register the pick in grant_id and go to LOCKED on the next edge.
  - Arbitration latency: 1 cycle from request seen in IDLE to first possible transfer.
- LOCKED (g = grant_id):
  - m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g], s_tready[g]=m_tready; all other s_tready=0.
  - All of these are combinational, zero-cycle, with no bubble between beats of one packet.
  - A beat transfers when s_tvalid[g] && m_tready.
  - On a transfer with s_tlast[g]=1: last_grant<=g, pkt_count<=pkt_count+1 (wraps modulo 2^CNT_WIDTH), state<=IDLE.
  - The grant is never revoked mid-packet. If s_tvalid[g] drops mid-packet, m_tvalid drops and the lock holds.
  - Other sources' s_tvalid is ignored while locked.
- Fairness:
  - Between two packets of the same source, the arbiter always passes through one IDLE cycle.
  - Any other pending source wins that IDLE cycle if it is next in rotation.
  - Worst-case wait for a requester: NUM_SRC-1 packets.
- busy=1 exactly in LOCKED.
- grant_id holds its value in IDLE after a packet completes.
- Single-beat packet (TLAST on first beat): LOCKED lasts 1 cycle if m_tready=1.
- Simultaneous requests in IDLE: only the rotation order decides the winner; there is no fixed priority beyond reset.
- Reset asserted mid-packet:
  - Immediate return to IDLE with outputs zeroed.
  - The partial packet is abandoned; downstream sees no TLAST.
  - pkt_count is cleared.
- NUM_SRC not a power of 2: the rotation wraps at NUM_SRC-1 to 0; unused grant_id codes never occur.

Test Plan:
- Single source:
  - Stimulus: source 0 sends 8 beats 0xdeadbeef..0xdeadbef6, TLAST on beat 8, m_tready=1.
  - Required: first transfer 1 cycle after s_tvalid[0] rises, 8 consecutive beats in order, then busy=0, pkt_count=1, grant_id=0.
- Round-robin contention:
  - Stimulus: all 4 sources continuously offer 2-beat packets with tdata = source_id<<28 | beat.
  - Required: grant order 0,1,2,3,0,1...; no interleaving within a packet; pkt_count=8 after 8 packets.
- Backpressure and bubbles:
  - Stimulus: source 2 locked, m_tready toggles 1/0 each cycle, and s_tvalid[2] drops for 2 cycles mid-packet.
  - Required: no lost or duplicated beats, grant_id stays 2 throughout, and source 1 (valid the whole time) gets s_tready=0 until TLAST.
- Back-to-back from the same source with a competitor:
  - Stimulus: source 1 finishes a packet while sources 1 and 3 both request.
  - Required: the next grant goes to 3, not 1.
- Reset mid-packet:
  - Stimulus: assert areset_n=0 after beat 3 of 8.
  - Required: m_tvalid=0, s_tready=0, busy=0, pkt_count=0 asynchronously.
  - Required after release: source 0 wins first if requesting.
- Counter wrap:
  - Stimulus: with CNT_WIDTH=4, send 17 single-beat packets.
  - Required: pkt_count=1.
